cnn_window_gen: RTL and testbench
=================================

Name: cnn_window_gen

Overview:
- Sliding-window producer that feeds the kernel MAC core.
- Accepts a raster-scan pixel stream of one IMG_H x IMG_W input feature-map channel.
- Buffers KY-1 lines plus a KY x KX window register and emits one packed KY*KX window per valid convolution position (stride 1, no padding).
- Output bus and valid drive the MAC core's i_in_FM / i_in_valid directly.

Parameters:
- KX, 3, kernel width in pixels
- KY, 3, kernel height in pixels
- BIT_IN_F, 8, bits per input feature pixel
- IMG_W, 8, feature-map width in pixels (must be >= KX)
- IMG_H, 8, feature-map height in pixels (must be >= KY)

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- i_soft_reset  input  1  synchronous clear, same effect as reset
- i_start  input  1  one-cycle pulse; begins a frame when IDLE
- i_pixel  input  BIT_IN_F  input pixel, raster order
- i_pixel_valid  input  1  i_pixel qualifier
- o_pixel_ready  output  1  block accepts a pixel this cycle
- o_window  output  KY*KX*BIT_IN_F  packed window
- o_window_valid  output  1  o_window qualifier, one-cycle pulse per window
- o_frame_done  output  1  one-cycle pulse after the last pixel of the frame

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk.
- Reset and soft reset values: state IDLE; row/col counters 0; line buffers and window registers 0; o_window=0; o_window_valid=0; o_pixel_ready=0; o_frame_done=0.
- Soft reset has priority over i_start and over pixel acceptance in the same cycle.
- A pixel is accepted when i_pixel_valid && o_pixel_ready. No other pixels are consumed.
- States:
  - IDLE: o_pixel_ready=0. i_start moves to RUN.
  - RUN: o_pixel_ready=1. Each accepted pixel advances col. When col wraps from IMG_W-1 to 0, row increments. Accepting pixel (IMG_H-1, IMG_W-1) moves to DONE.
  - DONE: o_pixel_ready=0, o_frame_done=1 for exactly one cycle, then IDLE.
- i_start outside IDLE is ignored.
- Reset mid-frame discards partial line data. The next frame begins from (0,0) after i_start.
- Window packing: element (ky,kx) occupies o_window[(ky*KX+kx)*BIT_IN_F +: BIT_IN_F].
  - ky=0 is the oldest (top) row; kx=0 is the leftmost (oldest) column.
  - Matches the MAC core's i_in_FM / i_weight layout.
- Accepting pixel (r,c) with r >= KY-1 and c >= KX-1 produces o_window_valid=1 in the next cycle (latency 1).
  - o_window then holds pixels (r-KY+1..r, c-KX+1..c).
- No window is produced for c < KX-1, including the line-wrap positions. Windows never straddle rows.
- Windows per frame: (IMG_H-KY+1)*(IMG_W-KX+1).
- o_window holds its last value when o_window_valid=0. o_window_valid is 0 in any cycle following a non-accepting cycle.
- Input gaps (i_pixel_valid low) stall all counters and buffers with no data loss.
- Line buffers: KY-1 rows of IMG_W entries. They advance only on accepted pixels.
- Pixels are passed unmodified (no arithmetic, no width change).
- No backpressure exists on the output side. The consumer must accept every o_window_valid pulse.

Optional Feature:
- Macro CNN_WINDOW_STRIDE2_EN.
- Defined: stride 2. A window is emitted only when (r-(KY-1)) and (c-(KX-1)) are both even.
  - Windows per frame: ((IMG_H-KY)/2+1)*((IMG_W-KX)/2+1).
  - All other timing is unchanged.
- Undefined: stride 1 as above.

Test Plan:
- Test 1, basic 8x8 frame, KX=KY=3:
  - Stimulus: reset, i_start, 64 back-to-back pixels with value r*8+c.
  - Response: 36 o_window_valid pulses.
  - First window, elements 0..8 = 0,1,2,8,9,10,16,17,18, one cycle after pixel 18 is accepted.
  - Last window = 45,46,47,53,54,55,61,62,63.
  - o_frame_done one cycle after pixel 63; o_pixel_ready then 0.
- Test 2, input gaps:
  - Stimulus: same frame with i_pixel_valid toggling 1/0 randomly.
  - Response: identical 36 windows in the same order; no window in a cycle after a non-accepted cycle.
- Test 3, row boundary:
  - Response: no o_window_valid after accepting pixels 24,25 (c=0,1) or 56,57.
  - Accepting pixel 26 yields window 8,9,10,16,17,18,24,25,26.
- Test 4, soft reset mid-frame:
  - Stimulus: assert i_soft_reset after pixel 30, then i_start and a new frame with value r*8+c+100.
  - Response: outputs return to 0. First window of the new frame = 100,101,102,108,109,110,116,117,118, with no stale data.
- Test 5, control edge cases:
  - i_start during RUN is ignored; the frame still completes with 36 windows.
  - Pixels with i_pixel_valid in IDLE are not accepted (o_pixel_ready=0).
  - i_start together with i_soft_reset leaves the state in IDLE.
- Test 6, CNN_WINDOW_STRIDE2_EN defined:
  - Stimulus: 8x8 frame.
  - Response: 9 windows, with top-left pixels 0,2,4,16,18,20,32,34,36.

Source files
------------

// File: rtl/cnn_window_gen.sv
// Sliding-window generator: turns a raster pixel stream into packed KYxKX windows for the MAC core.
// Build option: define CNN_WINDOW_STRIDE2_EN for stride-2 window emission (default stride 1).
module cnn_window_gen #(
    parameter int unsigned KX       = 3,
    parameter int unsigned KY       = 3,
    parameter int unsigned BIT_IN_F = 8,
    parameter int unsigned IMG_W    = 8,
    parameter int unsigned IMG_H    = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_soft_reset,
    input  logic                         i_start,
    input  logic [BIT_IN_F-1:0]          i_pixel,
    input  logic                         i_pixel_valid,
    output logic                         o_pixel_ready,
    output logic [KY*KX*BIT_IN_F-1:0]    o_window,
    output logic                         o_window_valid,
    output logic                         o_frame_done
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned WIN_W = KY * KX * BIT_IN_F;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [COL_W-1:0]     col_q;
    logic [ROW_W-1:0]     row_q;
    logic                 ready_q;
    logic                 valid_q;
    logic                 done_q;
    logic [WIN_W-1:0]     window_q;

    logic [BIT_IN_F-1:0]  lb_q     [KY-1][IMG_W];
    logic [BIT_IN_F-1:0]  win_q    [KY][KX];
    logic [BIT_IN_F-1:0]  win_d    [KY][KX];
    logic [BIT_IN_F-1:0]  colpix_c [KY];
    logic [WIN_W-1:0]     window_d;

    logic accept_c;
    logic last_col_c;
    logic last_row_c;
    logic stride_ok_c;
    logic emit_c;

    assign accept_c   = i_pixel_valid & ready_q;
    assign last_col_c = (col_q == COL_W'(IMG_W - 1));
    assign last_row_c = (row_q == ROW_W'(IMG_H - 1));

`ifdef CNN_WINDOW_STRIDE2_EN
    logic [ROW_W-1:0] row_off_c;
    logic [COL_W-1:0] col_off_c;
    assign row_off_c   = row_q - ROW_W'(KY - 1);
    assign col_off_c   = col_q - COL_W'(KX - 1);
    assign stride_ok_c = ~row_off_c[0] & ~col_off_c[0];
`else
    assign stride_ok_c = 1'b1;
`endif

    assign emit_c = accept_c
                  & (row_q >= ROW_W'(KY - 1))
                  & (col_q >= COL_W'(KX - 1))
                  & stride_ok_c;

    // New column: buffered rows on top (oldest first), incoming pixel at the bottom.
    always_comb begin
        colpix_c = '{default: '0};
        win_d    = '{default: '0};
        window_d = '0;
        for (int k = 0; k < KY - 1; k++) begin
            colpix_c[k] = lb_q[KY-2-k][col_q];
        end
        colpix_c[KY-1] = i_pixel;
        for (int ky = 0; ky < KY; ky++) begin
            for (int kx = 0; kx < KX - 1; kx++) begin
                win_d[ky][kx] = win_q[ky][kx+1];
            end
            win_d[ky][KX-1] = colpix_c[ky];
            for (int kx = 0; kx < KX; kx++) begin
                window_d[(ky*KX+kx)*BIT_IN_F +: BIT_IN_F] = win_d[ky][kx];
            end
        end
    end

    // Control FSM, raster counters, line buffers and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            col_q    <= '0;
            row_q    <= '0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            window_q <= '0;
            lb_q     <= '{default: '0};
            win_q    <= '{default: '0};
        end else if (i_soft_reset) begin
            state_q  <= S_IDLE;
            col_q    <= '0;
            row_q    <= '0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            window_q <= '0;
            lb_q     <= '{default: '0};
            win_q    <= '{default: '0};
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_q <= S_RUN;
                        ready_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (accept_c) begin
                        lb_q[0][col_q] <= i_pixel;
                        for (int k = 1; k < KY - 1; k++) begin
                            lb_q[k][col_q] <= lb_q[k-1][col_q];
                        end
                        win_q <= win_d;
                        if (emit_c) begin
                            valid_q  <= 1'b1;
                            window_q <= window_d;
                        end
                        if (last_col_c) begin
                            col_q <= '0;
                            if (last_row_c) begin
                                row_q   <= '0;
                                state_q <= S_DONE;
                                ready_q <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                row_q <= row_q + ROW_W'(1);
                            end
                        end else begin
                            col_q <= col_q + COL_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_pixel_ready  = ready_q;
    assign o_window       = window_q;
    assign o_window_valid = valid_q;
    assign o_frame_done   = done_q;

endmodule

// File: tb/tb_cnn_window_gen.sv
// Scoreboard bench for cnn_window_gen: reference windows are cut directly from the frame image.
module tb_cnn_window_gen;

    localparam int unsigned KX       = 3;
    localparam int unsigned KY       = 3;
    localparam int unsigned BIT_IN_F = 8;
    localparam int unsigned IMG_W    = 8;
    localparam int unsigned IMG_H    = 8;
    localparam int unsigned WIN_W    = KY * KX * BIT_IN_F;
`ifdef CNN_WINDOW_STRIDE2_EN
    localparam int unsigned STRIDE   = 2;
`else
    localparam int unsigned STRIDE   = 1;
`endif
    localparam int unsigned N_WIN    = ((IMG_H - KY) / STRIDE + 1) * ((IMG_W - KX) / STRIDE + 1);
    localparam int          N_PIX    = IMG_H * IMG_W;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 i_soft_reset = 1'b0;
    logic                 i_start = 1'b0;
    logic [BIT_IN_F-1:0]  i_pixel = '0;
    logic                 i_pixel_valid = 1'b0;
    logic                 o_pixel_ready;
    logic [WIN_W-1:0]     o_window;
    logic                 o_window_valid;
    logic                 o_frame_done;

    cnn_window_gen #(
        .KX(KX), .KY(KY), .BIT_IN_F(BIT_IN_F), .IMG_W(IMG_W), .IMG_H(IMG_H)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_soft_reset   (i_soft_reset),
        .i_start        (i_start),
        .i_pixel        (i_pixel),
        .i_pixel_valid  (i_pixel_valid),
        .o_pixel_ready  (o_pixel_ready),
        .o_window       (o_window),
        .o_window_valid (o_window_valid),
        .o_frame_done   (o_frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int win_seen = 0;
    int win_base = 0;
    int done_seen = 0;
    int frames_exp = 0;

    logic [BIT_IN_F-1:0] img [IMG_H][IMG_W];
    logic [WIN_W-1:0]    exp_q [$];
    logic [WIN_W-1:0]    last_win = '0;
    logic [WIN_W-1:0]    exp_w;
    logic [WIN_W-1:0]    hold_exp;
    logic                acc_prev = 1'b0;
    logic                clr_prev = 1'b0;

    task automatic check_n(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic bit is_win_pos(input int r, input int c);
        return (r >= KY - 1) && (c >= KX - 1) &&
               (((r - (KY - 1)) % STRIDE) == 0) && (((c - (KX - 1)) % STRIDE) == 0);
    endfunction

    function automatic logic [WIN_W-1:0] build_window(input int r, input int c);
        logic [WIN_W-1:0] w;
        w = '0;
        for (int ky = 0; ky < KY; ky++)
            for (int kx = 0; kx < KX; kx++)
                w[(ky*KX+kx)*BIT_IN_F +: BIT_IN_F] = img[r-KY+1+ky][c-KX+1+kx];
        return w;
    endfunction

    // Monitor: pops the scoreboard on every window and checks output hold behaviour.
    always @(negedge clk) begin
        if (o_frame_done) done_seen++;
        if (!reset_n) begin
            last_win = '0;
        end else begin
            if (o_window_valid) begin
                win_seen++;
                total++;
                if (!acc_prev) begin
                    bad++;
                    $display("FAIL valid_without_accept: got valid=1 want 0");
                end
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_window: got %h want none", o_window);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (o_window !== exp_w) begin
                        bad++;
                        $display("FAIL window: got %h want %h", o_window, exp_w);
                    end
                end
            end else begin
                hold_exp = clr_prev ? '0 : last_win;
                total++;
                if (o_window !== hold_exp) begin
                    bad++;
                    $display("FAIL window_hold: got %h want %h", o_window, hold_exp);
                end
            end
            last_win = o_window;
        end
        acc_prev = i_pixel_valid && o_pixel_ready && !i_soft_reset && reset_n;
        clr_prev = i_soft_reset;
    end

    task automatic pulse_start();
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    // Drive n_pix pixels of frame (base + raster index); expected windows pushed on acceptance.
    task automatic run_frame(input int base, input int gap_pct, input int n_pix, input int start_idx);
        int r;
        int c;
        bit ok;
        for (int idx = 0; idx < N_PIX; idx++)
            img[idx / IMG_W][idx % IMG_W] = BIT_IN_F'(base + idx);
        win_base = win_seen;
        for (int idx = 0; idx < n_pix; idx++) begin
            r = idx / IMG_W;
            c = idx % IMG_W;
            while ($urandom_range(99) < gap_pct) begin
                i_pixel_valid = 1'b0;
                i_pixel = BIT_IN_F'($urandom);
                @(posedge clk); #1;
            end
            i_pixel       = img[r][c];
            i_pixel_valid = 1'b1;
            i_start       = (idx == start_idx);
            ok = 1'b0;
            for (int t = 0; t < 20 && !ok; t++) begin
                @(negedge clk);
                if (o_pixel_ready) begin
                    ok = 1'b1;
                    if (is_win_pos(r, c)) exp_q.push_back(build_window(r, c));
                end
                @(posedge clk); #1;
                i_start = 1'b0;
            end
            if (!ok) check_n("pixel_accept_timeout", 0, 1);
        end
        i_pixel_valid = 1'b0;
        i_start = 1'b0;
    endtask

    task automatic finish_frame();
        frames_exp++;
        @(negedge clk);
        check_n("frame_done_pulse", int'(o_frame_done), 1);
        check_n("ready_after_last", int'(o_pixel_ready), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_n("frame_done_end", int'(o_frame_done), 0);
        check_n("ready_idle", int'(o_pixel_ready), 0);
        check_n("windows_per_frame", win_seen - win_base, int'(N_WIN));
        check_n("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic check_cleared(input string tag);
        check_n({tag, "_window_zero"}, int'(o_window == '0), 1);
        check_n({tag, "_valid"}, int'(o_window_valid), 0);
        check_n({tag, "_ready"}, int'(o_pixel_ready), 0);
        check_n({tag, "_done"}, int'(o_frame_done), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check_cleared("reset");

        // Pixels offered in IDLE must not be consumed.
        for (int i = 0; i < 4; i++) begin
            i_pixel_valid = 1'b1;
            i_pixel = BIT_IN_F'($urandom);
            @(negedge clk);
            check_n("idle_not_ready", int'(o_pixel_ready), 0);
            @(posedge clk); #1;
        end
        i_pixel_valid = 1'b0;

        // Back-to-back frame, value r*W+c.
        pulse_start();
        run_frame(0, 0, N_PIX, -1);
        finish_frame();

        // Same frame with random input gaps.
        pulse_start();
        run_frame(0, 50, N_PIX, -1);
        finish_frame();

        // Soft reset mid-frame, then a fresh frame offset by 100.
        pulse_start();
        run_frame(0, 20, 31, -1);
        i_soft_reset = 1'b1;
        @(posedge clk); #1;
        i_soft_reset = 1'b0;
        @(negedge clk);
        check_cleared("soft_reset");
        check_n("soft_reset_queue", exp_q.size(), 0);
        @(posedge clk); #1;
        pulse_start();
        run_frame(100, 0, N_PIX, -1);
        finish_frame();

        // i_start mid-frame is ignored.
        pulse_start();
        run_frame(7, 30, N_PIX, 20);
        finish_frame();

        // i_start together with soft reset stays in IDLE.
        i_start = 1'b1;
        i_soft_reset = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_soft_reset = 1'b0;
        i_pixel_valid = 1'b1;
        @(negedge clk);
        check_n("start_with_soft_reset", int'(o_pixel_ready), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_n("start_with_soft_reset_2", int'(o_pixel_ready), 0);
        @(posedge clk); #1;
        i_pixel_valid = 1'b0;

        // Asynchronous reset mid-frame, then a full frame.
        pulse_start();
        run_frame(50, 0, 38, -1);
        reset_n = 1'b0;
        #1;
        check_cleared("async_reset");
        exp_q.delete();
        @(posedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;
        pulse_start();
        run_frame(200, 10, N_PIX, -1);
        finish_frame();

        repeat (3) @(posedge clk);
        #1;
        check_n("frame_done_count", done_seen, frames_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
